// File: rtl/mem_arbiter.sv
// Two-master lock-aware round-robin arbiter for one data_memory port; MEMARB_TIMEOUT_EN adds a forced lock release.
// Grant 1 cycle after request, read data 1 cycle after the transfer; a master stalls while gnt is low.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_m0_req,
  input  logic              I_m0_lock,
  input  logic              I_m0_we,
  input  logic [ADDR_W-1:0] I_m0_addr,
  input  logic [DATA_W-1:0] I_m0_wdata,
  input  logic              I_m1_req,
  input  logic              I_m1_lock,
  input  logic              I_m1_we,
  input  logic [ADDR_W-1:0] I_m1_addr,
  input  logic [DATA_W-1:0] I_m1_wdata,
  output logic              O_m0_gnt,
  output logic              O_m1_gnt,
  output logic [DATA_W-1:0] O_m0_rdata,
  output logic [DATA_W-1:0] O_m1_rdata,
  output logic              O_m0_rvalid,
  output logic              O_m1_rvalid,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  input  logic [DATA_W-1:0] I_mem_rdata,
  output logic              O_timeout_err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;   // 0 favours m0 on a tie
  logic              ready_q;          // blocks arbitration on the first edge after reset release
  logic              rd0, rd1;
  logic              tmo_fire;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (ready_q) begin
          if (I_m0_req && (!I_m1_req || !prio_q)) state_d = OWN0;
          else if (I_m1_req)                      state_d = OWN1;
        end
      end
      OWN0: begin
        prio_d = 1'b1;
        if (tmo_fire)       state_d = OWN1;
        else if (I_m0_lock) state_d = OWN0;
        else if (I_m1_req)  state_d = OWN1;
        else if (!I_m0_req) state_d = IDLE;
      end
      OWN1: begin
        prio_d = 1'b0;
        if (tmo_fire)       state_d = OWN0;
        else if (I_m1_lock) state_d = OWN1;
        else if (I_m0_req)  state_d = OWN0;
        else if (!I_m1_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    O_mem_we    = 1'b0;
    O_mem_addr  = '0;
    O_mem_wdata = '0;
    rd0         = 1'b0;
    rd1         = 1'b0;
    case (state_q)
      OWN0: begin
        O_mem_we    = I_m0_req & I_m0_we;
        O_mem_addr  = I_m0_addr;
        O_mem_wdata = I_m0_wdata;
        rd0         = I_m0_req & ~I_m0_we;
      end
      OWN1: begin
        O_mem_we    = I_m1_req & I_m1_we;
        O_mem_addr  = I_m1_addr;
        O_mem_wdata = I_m1_wdata;
        rd1         = I_m1_req & ~I_m1_we;
      end
      default: ;
    endcase
  end

  assign O_m0_gnt = (state_q == OWN0);
  assign O_m1_gnt = (state_q == OWN1);

  // Read return is tagged at issue time, so an ownership change at the same edge cannot misroute it.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rd0;
      rvalid1_q <= rd1;
      if (rvalid0_q) rdata0_q <= I_mem_rdata;
      if (rvalid1_q) rdata1_q <= I_mem_rdata;
    end
  end

  assign O_m0_rvalid = rvalid0_q;
  assign O_m1_rvalid = rvalid1_q;
  assign O_m0_rdata  = rvalid0_q ? I_mem_rdata : rdata0_q;
  assign O_m1_rdata  = rvalid1_q ? I_mem_rdata : rdata1_q;

`ifdef MEMARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       locked;
  logic       err_q;

  assign locked   = (state_q == OWN0 && I_m0_lock) || (state_q == OWN1 && I_m1_lock);
  // cnt_q holds the locked cycles already completed, so the TIMEOUT-th locked cycle is the last.
  assign tmo_fire = locked && (cnt_q >= 8'(TIMEOUT - 1)) &&
                    ((state_q == OWN0) ? I_m1_req : I_m0_req);

  always_comb begin
    cnt_d = '0;
    if (locked && state_d == state_q)
      cnt_d = (cnt_q < 8'(TIMEOUT - 1)) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= tmo_fire;
    end
  end

  assign O_timeout_err = err_q;
`else
  assign tmo_fire      = 1'b0;
  assign O_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for arbitration/lock, hand sequences for read, timeout and reset.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam logic [2:0] NO  = 3'b000;  // {req, lock, we}
  localparam logic [2:0] RD  = 3'b100;
  localparam logic [2:0] LRD = 3'b110;
  localparam logic [2:0] WR  = 3'b101;
  localparam logic [2:0] LWR = 3'b111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, mem_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, mem_wdata, mem_rdata;
  logic          gnt0, gnt1, rv0, rv1, mem_we, tmo_err;
  logic [DW-1:0] rdata0, rdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_m0_req(m0_req), .I_m0_lock(m0_lock), .I_m0_we(m0_we), .I_m0_addr(m0_addr), .I_m0_wdata(m0_wdata),
    .I_m1_req(m1_req), .I_m1_lock(m1_lock), .I_m1_we(m1_we), .I_m1_addr(m1_addr), .I_m1_wdata(m1_wdata),
    .O_m0_gnt(gnt0), .O_m1_gnt(gnt1), .O_m0_rdata(rdata0), .O_m1_rdata(rdata1),
    .O_m0_rvalid(rv0), .O_m1_rvalid(rv1), .O_mem_we(mem_we), .O_mem_addr(mem_addr),
    .O_mem_wdata(mem_wdata), .I_mem_rdata(mem_rdata), .O_timeout_err(tmo_err)
  );

  // Memory model: unwritten words return a fixed pattern, word 4 (byte 0x10) holds 0xDEADBEEF.
  bit [DW-1:0] mem [256];
  bit          written [256];

  function automatic logic [DW-1:0] dflt(input logic [7:0] idx);
    return (idx == 8'd4) ? 32'hDEADBEEF : {24'hC0FFEE, idx};
  endfunction

  function automatic logic [DW-1:0] rd_word(input logic [7:0] idx);
    return written[idx] ? mem[idx] : dflt(idx);
  endfunction

  always @(posedge clk) begin
    mem_rdata <= rd_word(mem_addr[9:2]);
    if (mem_we) begin
      mem[mem_addr[9:2]]     <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
  end

  typedef struct {
    logic [2:0]  c0;
    logic [31:0] a0, d0;
    logic [2:0]  c1;
    logic [31:0] a1, d1;
    logic [1:0]  eg;    // {gnt1, gnt0}
    logic        ewe;
    logic [31:0] ea;
    logic [1:0]  erv;   // {rvalid1, rvalid0}
  } vec_t;

  function automatic vec_t mk(input logic [2:0] c0, input logic [31:0] a0, d0,
                              input logic [2:0] c1, input logic [31:0] a1, d1,
                              input logic [1:0] eg, input logic ewe,
                              input logic [31:0] ea, input logic [1:0] erv);
    vec_t v;
    v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1;
    v.eg = eg; v.ewe = ewe; v.ea = ea; v.erv = erv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] c0, input logic [31:0] a0, d0,
                       input logic [2:0] c1, input logic [31:0] a1, d1);
    {m0_req, m0_lock, m0_we} = c0; m0_addr = a0; m0_wdata = d0;
    {m1_req, m1_lock, m1_we} = c1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " gnt"}, {gnt1, gnt0}, 2'b00);
    chk({nm, " rvalid"}, {rv1, rv0}, 2'b00);
    chk({nm, " rdata"}, {rdata1, rdata0}, 64'h0);
    chk({nm, " mem_we/err"}, {mem_we, tmo_err}, 2'b00);
    chk({nm, " mem_addr"}, mem_addr, 0);
    chk({nm, " mem_wdata"}, mem_wdata, 0);
  endtask

  // Returns just after the first edge following release (the edge that enables arbitration).
  task automatic do_reset();
    rst_n = 1'b0;
    drive(NO, 0, 0, NO, 0, 0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  vec_t tv [15];
  int   x0, x1, g0_before, err_cnt;
  logic seen1, err_at_switch;

  initial begin
    tv[0]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b00, 0, 'h0,  2'b00);
    tv[1]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b01, 0, 'h10, 2'b00);
    tv[2]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b10, 0, 'h14, 2'b01);
    tv[3]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b01, 0, 'h10, 2'b10);
    tv[4]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b10, 0, 'h14, 2'b01);
    tv[5]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b01, 0, 'h10, 2'b10);
    tv[6]  = mk(RD, 'h10, 0, RD, 'h14, 0,       2'b10, 0, 'h14, 2'b01);
    tv[7]  = mk(NO, 0,    0, NO, 0,    0,       2'b01, 0, 'h0,  2'b10);
    tv[8]  = mk(NO, 0,    0, NO, 0,    0,       2'b00, 0, 'h0,  2'b00);
    tv[9]  = mk(RD, 'h40, 0, LWR, 'h20, 'h1111, 2'b00, 0, 'h0,  2'b00);
    tv[10] = mk(RD, 'h40, 0, LWR, 'h20, 'h1111, 2'b10, 1, 'h20, 2'b00);
    tv[11] = mk(RD, 'h40, 0, WR,  'h20, 'h2222, 2'b10, 1, 'h20, 2'b00);
    tv[12] = mk(RD, 'h40, 0, NO, 0,    0,       2'b01, 0, 'h40, 2'b00);
    tv[13] = mk(NO, 0,    0, NO, 0,    0,       2'b01, 0, 'h0,  2'b01);
    tv[14] = mk(NO, 0,    0, NO, 0,    0,       2'b00, 0, 'h0,  2'b00);

    // Arbitration and lock table from a fresh reset
    do_reset();
    x0 = 0; x1 = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(tv[i].c0, tv[i].a0, tv[i].d0, tv[i].c1, tv[i].a1, tv[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i), {gnt1, gnt0}, tv[i].eg);
      chk($sformatf("vec%0d mem_we", i), mem_we, tv[i].ewe);
      chk($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].ea);
      chk($sformatf("vec%0d rvalid", i), {rv1, rv0}, tv[i].erv);
      chk($sformatf("vec%0d excl", i), gnt0 & gnt1, 0);
      if (tv[i].ewe) chk($sformatf("vec%0d wdata", i), mem_wdata, tv[i].d1);
      if (i <= 6) begin
        if (gnt0 && m0_req) x0++;
        if (gnt1 && m1_req) x1++;
      end
    end
    chk("contention xfers m0", x0, 3);
    chk("contention xfers m1", x1, 3);
    chk("locked write result", rd_word(8'd8), 32'h2222);

    // Single read with data hold
    do_reset();
    @(posedge clk); #1 drive(RD, 'h10, 0, NO, 0, 0);
    @(negedge clk); chk("read gnt0 latency", gnt0, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("read gnt0", gnt0, 1); chk("read mem_addr", mem_addr, 'h10);
    @(posedge clk); #1 drive(NO, 0, 0, NO, 0, 0);
    @(negedge clk);
    chk("read rvalid0", rv0, 1);
    chk("read rdata0", rdata0, 32'hDEADBEEF);
    chk("read m1 quiet", {gnt1, rv1, rdata1}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("read rvalid0 pulse", rv0, 0);
    chk("read rdata0 hold", rdata0, 32'hDEADBEEF);
    chk("read back to idle", gnt0, 0);

    // Locked m0 against a requesting m1
    do_reset();
    @(posedge clk); #1 drive(LRD, 'h10, 0, RD, 'h14, 0);
    seen1 = 1'b0; err_at_switch = 1'b0; g0_before = 0; err_cnt = 0;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      chk($sformatf("lock excl %0d", k), gnt0 & gnt1, 0);
      if (gnt1 && !seen1) begin seen1 = 1'b1; err_at_switch = tmo_err; end
      if (gnt0 && !seen1) g0_before++;
      if (tmo_err) err_cnt++;
      @(posedge clk); #1;
      if (seen1) m1_req = 1'b0;
    end
`ifdef MEMARB_TIMEOUT_EN
    chk("timeout locked cycles", g0_before, TO);
    chk("timeout switched", seen1, 1);
    chk("timeout err at switch", err_at_switch, 1);
    chk("timeout err pulses", err_cnt, 1);
`else
    chk("lock held cycles", g0_before, 50);
    chk("lock never switched", seen1, 0);
    chk("lock no timeout_err", err_cnt, 0);
`endif

    // Reset in the cycle after a read transfer
    do_reset();
    @(posedge clk); #1 drive(RD, 'h10, 0, NO, 0, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("rst-read gnt0", gnt0, 1);
    @(posedge clk); #1 rst_n = 1'b0; drive(NO, 0, 0, NO, 0, 0);
    @(negedge clk); chk_all_zero("mid-read reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(NO, 0, 0, RD, 'h14, 0);
    @(negedge clk);
    chk("post-reset first edge gnt1", gnt1, 0);
    chk("post-reset no rvalid0", rv0, 0);
    @(negedge clk);
    chk("post-reset gnt1", gnt1, 1);
    chk("post-reset mem_addr", mem_addr, 'h14);
    @(posedge clk); #1 drive(NO, 0, 0, NO, 0, 0);
    @(negedge clk);
    chk("post-reset rvalid1", {rv1, rv0}, 2'b10);
    chk("post-reset rdata1", rdata1, 32'hC0FFEE05);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
